// File: rtl/lane_sched_pkg.sv
// Shared types and helpers for the car-lane scheduler.
package lane_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  // Lane i advances once every 1..4 base ticks, repeating every four lanes.
  function automatic int unsigned lane_period(input int unsigned i);
    return 1 + (i % 4);
  endfunction

  // Rotate a 10-bit value left by n bits so each lane sees a different
  // view of the shared LFSR.
  function automatic logic [9:0] rotl10(input logic [9:0] v, input int unsigned n);
    logic [19:0] d;
    d = {v, v} << (n % 10);
    return d[19:10];
  endfunction

endpackage

// File: rtl/lane_scheduler_tick_prescaler.sv
// Divides clk down to the base game tick. Counts only while enabled and
// holds otherwise, so a paused game resumes mid-period without losing time.
module tick_prescaler
  import lane_sched_pkg::*;
#(
  parameter int DIV = 6_250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] PC_MAX = W'(DIV - 1);

  logic [W-1:0] pc;

  assign tick = en && (pc == PC_MAX);

  // Prescale counter: clear has priority, wraps to zero on the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (en) begin
      if (tick) pc <= '0;
      else      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/lane_scheduler.sv
// Car-lane sequencing controller: game FSM, per-lane speed and spawn-gap
// counters, and registered press/load strobes for the car shift registers.
module lane_scheduler
  import lane_sched_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DIV   = 6_250_000,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             game_over,
  input  logic [8:0]       sw,
  input  logic [9:0]       rand10,
  output logic [LANES-1:0] press,
  output logic [LANES-1:0] load,
  output logic [1:0]       state,
  output logic [15:0]      step_count
);

  localparam logic [2:0] GAP_V = 3'(GAP);

  state_t           st;
  logic             init;
  logic             bt;
  logic [LANES-1:0] fire_c;
  logic [LANES-1:0] load_c;
  logic [LANES-1:0] press_p1;
  logic [LANES-1:0] load_p1;

  assign state = st;

  // A new game starts only from IDLE/OVER, and a simultaneous game_over wins.
  assign init = ((st == IDLE) || (st == OVER)) && start && !game_over;

  // Game FSM: game_over beats everything, start is ignored mid-game.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
    end else if (game_over) begin
      st <= OVER;
    end else begin
      case (st)
        IDLE, OVER: if (start)  st <= RUN;
        RUN:        if (pause)  st <= PAUSED;
        PAUSED:     if (!pause) st <= RUN;
        default:    st <= IDLE;
      endcase
    end
  end

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (st == RUN),
    .clr  (init),
    .tick (bt)
  );

  // ---- stage 0: base tick, lane fire and spawn decisions ----
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [1:0] RELOAD = 2'(lane_period(i) - 1);

    logic [1:0] lc;
    logic [2:0] gc;
    logic       spawn;

    assign fire_c[i] = bt && (lc == 2'd0);
    assign spawn     = {1'b0, sw} > rotl10(rand10, i);
    assign load_c[i] = fire_c[i] && spawn && (gc == 3'd0);

    // Lane speed down-counter and post-spawn gap counter, both advanced on the base tick.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lc <= 2'd0;
        gc <= 3'd0;
      end else if (init) begin
        lc <= 2'd0;
        gc <= 3'd0;
      end else if (bt) begin
        lc <= fire_c[i] ? RELOAD : lc - 2'd1;
        if (load_c[i])                    gc <= GAP_V;
        else if (fire_c[i] && gc != 3'd0) gc <= gc - 3'd1;
      end
    end
  end

  // Base-tick counter shown on the display, held at its ceiling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_count <= 16'd0;
    end else if (init) begin
      step_count <= 16'd0;
    end else if (bt && step_count != 16'hFFFF) begin
      step_count <= step_count + 16'd1;
    end
  end

  // ---- stage 1: registered one-cycle strobes ----
  // Strobes follow the tick by one cycle; they carry the tick's decision even
  // if the FSM leaves RUN on that same edge, and are idle otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_p1 <= '0;
      load_p1  <= '0;
    end else begin
      press_p1 <= fire_c;
      load_p1  <= load_c;
    end
  end

  assign press = press_p1;
  assign load  = load_p1;

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench for lane_scheduler (DIV=4, LANES=4, GAP=2).
module tb_lane_scheduler;

  localparam int DIV   = 4;
  localparam int LANES = 4;
  localparam int GAP   = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic       game_over;
  logic [8:0] sw;
  logic [9:0] rand10;
  logic [3:0] press;
  logic [3:0] load;
  logic [1:0] state;
  logic [15:0] step_count;

  lane_scheduler #(.LANES(LANES), .DIV(DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .game_over (game_over),
    .sw        (sw),
    .rand10    (rand10),
    .press     (press),
    .load      (load),
    .state     (state),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] load;
    int         step;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  // reference game state (0 IDLE, 1 RUN, 2 PAUSED, 3 OVER)
  int m_st, m_pc, m_step;
  int m_lc[4];
  int m_gc[4];
  int n_st, n_pc, n_step;
  int n_lc[4];
  int n_gc[4];

  // monitor observations
  int lane_cnt[4];
  int first_pc;
  logic [3:0] first_vec;
  int last_press_cyc;
  int npress;
  bit l0_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rotl(input int v, input int n);
    return ((v << n) | (v >> (10 - n))) & 1023;
  endfunction

  // Reference game rules applied to the current inputs, giving the state
  // after the next clock edge and any strobes that edge produces.
  task automatic model_step();
    bit bt;
    logic [3:0] f;
    logic [3:0] l;
    f = '0;
    l = '0;
    n_st = m_st; n_pc = m_pc; n_step = m_step;
    for (int i = 0; i < 4; i++) begin n_lc[i] = m_lc[i]; n_gc[i] = m_gc[i]; end
    if (reset) begin
      n_st = 0; n_pc = 0; n_step = 0;
      for (int i = 0; i < 4; i++) begin n_lc[i] = 0; n_gc[i] = 0; end
      return;
    end
    bt = (m_st == 1) && (m_pc == DIV - 1);
    for (int i = 0; i < 4; i++) begin
      if (bt && m_lc[i] == 0) begin
        f[i] = 1'b1;
        n_lc[i] = i % 4;
        if (int'(sw) > rotl(int'(rand10), i) && m_gc[i] == 0) begin
          l[i] = 1'b1;
          n_gc[i] = GAP;
        end else if (m_gc[i] > 0) begin
          n_gc[i] = m_gc[i] - 1;
        end
      end else if (bt) begin
        n_lc[i] = m_lc[i] - 1;
      end
    end
    if (m_st == 1) n_pc = bt ? 0 : m_pc + 1;
    if (bt && m_step < 65535) n_step = m_step + 1;
    if (game_over) begin
      n_st = 3;
    end else if ((m_st == 0 || m_st == 3) && start) begin
      n_st = 1; n_pc = 0; n_step = 0;
      for (int i = 0; i < 4; i++) begin n_lc[i] = 0; n_gc[i] = 0; end
    end else if (m_st == 1 && pause) begin
      n_st = 2;
    end else if (m_st == 2 && !pause) begin
      n_st = 1;
    end
    if (f != 0) q.push_back('{cyc: cyc + 1, press: f, load: l, step: n_step});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    m_st = n_st; m_pc = n_pc; m_step = n_step;
    for (int i = 0; i < 4; i++) begin m_lc[i] = n_lc[i]; m_gc[i] = n_gc[i]; end
    cyc++;
    #1;
  endtask

  task automatic model_clear();
    m_st = 0; m_pc = 0; m_step = 0;
    for (int i = 0; i < 4; i++) begin m_lc[i] = 0; m_gc[i] = 0; end
  endtask

  // Asynchronous reset in the middle of a clock phase.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    model_clear();
    while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
    #1;
    chk("reset_press", 32'(press), 32'h0);
    chk("reset_load", 32'(load), 32'h0);
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_step", 32'(step_count), 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) lane_cnt[i] = 0;
    first_pc = -1;
    first_vec = '0;
    npress = 0;
    l0_hist.delete();
  endtask

  task automatic restart();
    game_over = 1'b1;
    cycle();
    game_over = 1'b0;
    cycle();
    clear_obs();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Monitor: compares every cycle's state and step count, and pops the
  // scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("state", 32'(state), 32'(m_st));
      chk("step_count", 32'(step_count), 32'(m_step));
      if (press != 0 || load != 0) begin
        for (int i = 0; i < 4; i++) if (press[i]) lane_cnt[i]++;
        if (first_pc < 0) begin first_pc = cyc; first_vec = press; end
        last_press_cyc = cyc;
        npress++;
        if (press[0]) l0_hist.push_back(load[0]);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe at cycle %0d: press %0h load %0h expected none", cyc, press, load);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("press", 32'(press), 32'(e.press));
          chk("load", 32'(load), 32'(e.load));
          chk("strobe_step", 32'(step_count), 32'(e.step));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_strobe at cycle %0d: press 0 expected %0h", cyc, e.press);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int rel;
    int n;
    int p0;
    reset = 1'b0; start = 1'b0; pause = 1'b0; game_over = 1'b0;
    sw = '0; rand10 = '0;
    last_press_cyc = -1;
    clear_obs();

    // Reset/idle
    #3;
    reset = 1'b1;
    model_clear();
    mon_en = 1'b1;
    #1;
    chk("por_state", 32'(state), 32'h0);
    chk("por_press", 32'(press), 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sw = 9'($urandom);
      rand10 = 10'($urandom);
      cycle();
    end
    chk("idle_npress", 32'(npress), 32'h0);

    // Lane rates
    sw = 9'h000;
    clear_obs();
    c0 = cyc;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 49; k++) begin
      rand10 = 10'($urandom);
      cycle();
    end
    chk("first_press_latency", 32'(first_pc - c0), 32'd5);
    chk("lane0_count", 32'(lane_cnt[0]), 32'd12);
    chk("lane1_count", 32'(lane_cnt[1]), 32'd6);
    chk("lane2_count", 32'(lane_cnt[2]), 32'd4);
    chk("lane3_count", 32'(lane_cnt[3]), 32'd3);

    // Spawn gap
    sw = 9'h1FF;
    rand10 = 10'h000;
    restart();
    repeat (30) cycle();
    if (l0_hist.size() < 6) begin
      checks++;
      errors++;
      $display("FAIL gap_pattern_len: got %0d presses expected at least 6", l0_hist.size());
    end else begin
      logic [5:0] pat;
      pat = 6'b001001;
      for (int k = 0; k < 6; k++) chk("gap_pattern", 32'(l0_hist[k]), 32'(pat[k]));
    end

    // Comparison edge
    sw = 9'h100; rand10 = 10'h0FF;
    restart();
    repeat (6) cycle();
    chk("edge_0ff_load", 32'((l0_hist.size() > 0) ? l0_hist[0] : 1'bx), 32'd1);
    rand10 = 10'h100;
    restart();
    repeat (6) cycle();
    chk("edge_100_load", 32'((l0_hist.size() > 0) ? l0_hist[0] : 1'bx), 32'd0);
    rand10 = 10'h200;
    restart();
    repeat (6) cycle();
    chk("edge_200_load", 32'((l0_hist.size() > 0) ? l0_hist[0] : 1'bx), 32'd0);

    // Pause at prescale phase 2
    sw = 9'h0C0;
    n = 0;
    while (!(m_st == 1 && m_pc == 2) && n < 20) begin
      rand10 = 10'($urandom);
      cycle();
      n++;
    end
    chk("pause_phase_reached", 32'(n < 20), 32'd1);
    p0 = npress;
    pause = 1'b1;
    repeat (10) cycle();
    pause = 1'b0;
    chk("pause_no_press", 32'(npress - p0), 32'd0);
    rel = cyc;
    n = 0;
    while (last_press_cyc <= rel && n < 20) begin
      cycle();
      n++;
    end
    chk("resume_press_delay", 32'(last_press_cyc - rel), 32'd2);

    // Priority: game_over beats start in RUN
    game_over = 1'b1; start = 1'b1;
    cycle();
    game_over = 1'b0; start = 1'b0;
    chk("prio_over", 32'(state), 32'd3);
    repeat (3) cycle();
    clear_obs();
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_step", 32'(step_count), 32'd0);
    repeat (6) cycle();
    chk("restart_all_fire", 32'(first_vec), 32'hF);

    // Randomised play
    for (int k = 0; k < 1500; k++) begin
      sw = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
      rand10 = 10'($urandom);
      start = ($urandom_range(0, 49) == 0);
      game_over = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      cycle();
      if (k == 700) begin
        start = 1'b0; game_over = 1'b0;
        mid_reset();
      end
    end
    start = 1'b0; game_over = 1'b0; pause = 1'b0;
    repeat (4) cycle();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_scheduler.md
# lane_scheduler

Sequencing controller for the frog-crossing playfield's car lanes. Generates per-lane shift strobes (`press`) and spawn strobes (`load`) for LANES `car_move` shift registers. Derives a base game tick from `clk`, runs each lane at its own fixed speed, and gates car spawning with the switch-set difficulty against the 10-bit LFSR value. Enforces a minimum gap between spawned cars so every lane stays passable.

## Interface
- `LANES`, default 4: number of car lanes driven.
- `DIV`, default 6_250_000: `clk` cycles per base tick; must be ≥2.
- `GAP`, default 2: minimum non-spawning presses after each spawn in a lane; range 0..7.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse, already debounced; begins or restarts a game.
- `pause` in 1: level; freezes the game while high.
- `game_over` in 1: level or pulse from collision logic.
- `sw` in 9: difficulty setting.
- `rand10` in 10: free-running LFSR_10 value.
- `press` out LANES: one-cycle shift strobe per lane.
- `load` out LANES: spawn strobe per lane; only ever high together with the same lane's `press`.
- `state` out 2: IDLE=0, RUN=1, PAUSED=2, OVER=3.
- `step_count` out 16: number of base ticks in the current game, saturating.

## Operation
- FSM, priority in this order:
  - `game_over`=1 → OVER from any state.
  - IDLE/OVER + `start` → RUN, reinitialising all counters.
  - RUN + `pause` → PAUSED.
  - PAUSED + !`pause` → RUN.
  - `start` in RUN or PAUSED is ignored.
- Prescaler `pc` counts 0..DIV-1 only in RUN and holds in other states. Base tick `bt` = RUN && `pc`==DIV-1; on `bt`, `pc` wraps to 0.
- Lane i period is P_i = 1 + (i mod 4) base ticks. Per-lane down-counter `lc_i`:
  - On `bt` with `lc_i`==0: lane fires and `lc_i` ← P_i-1.
  - On `bt` with `lc_i`≠0: `lc_i` decrements.
- Spawn test for lane i: {1'b0,`sw`} > rot_i, where rot_i is `rand10` rotated left by i bits, sampled on the `bt` cycle. `sw`=0 never spawns; `sw`=511 spawns whenever rot_i < 511.
- Gap counter `gc_i` (3 bits):
  - `load_i` = fire_i && spawn_i && `gc_i`==0.
  - If `load_i` is set: `gc_i` ← GAP.
  - Else if fire_i && `gc_i`>0: `gc_i` decrements.
- `step_count` increments on every `bt` and saturates at 16'hFFFF.
- Initialisation on reset or `start`: `pc`=0, all `lc_i`=0, all `gc_i`=0, `step_count`=0. Every lane therefore fires on the first base tick.

## Timing
- Reset values: `state`=IDLE, `press`=0, `load`=0, `step_count`=0.
- `press`/`load` are registered, asserted the cycle after `bt`, and last exactly one cycle.
- The first `press` comes DIV+1 cycles after the `start` cycle, including one cycle for the FSM to enter RUN.
- Outputs of the `bt` cycle still register even if `pause` or `game_over` rises in that same cycle.
- From the following cycle on, `press`/`load` are forced to 0 outside RUN.
- PAUSED resumes with `pc`, `lc`, and `gc` unchanged. No tick is lost or duplicated.
- OVER holds `step_count` for display. `start` clears it.
- Asserting `reset` mid-game clears everything immediately, without waiting for a clock edge.

## Structure
- Package `lane_sched_pkg`:
  - `state_t` enum (IDLE, RUN, PAUSED, OVER).
  - function `lane_period(i)` returning 1 + (i mod 4).
  - function `rotl10(v, n)`.
- Sub-module `tick_prescaler` (`clk`, `reset`, `en`, `clr`, `tick`), parameterised by DIV.
- Top level contains the FSM, the per-lane counter generate loop, and the output registers.

## Test plan
Test configuration: DIV=4, LANES=4, GAP=2.
- **Reset/idle:** assert `reset` mid-clock, then run 20 cycles without `start` → `state`=0, `press`=0, `load`=0, `step_count`=0 throughout.
- **Lane rates:** `start`, `sw`=0, run 48 cycles → `press` rises 5 cycles after `start`, then every 4 cycles. Over 12 base ticks, lanes 0..3 fire 12, 6, 4, 3 times. `load` stays 0.
- **Spawn gap:** `sw`=511, `rand10` held at 0 → lane 0 `load` pattern 1,0,0,1,0,0… on consecutive presses.
- **Comparison edge:** `sw`=9'h100, `rand10`=10'h0FF → lane 0 loads. With `rand10`=10'h100 → no load. With `rand10`=10'h200 → no load; the 10-bit width is confirmed.
- **Pause:** assert `pause` for 10 cycles at `pc`=2 → no `press` while paused. The next `press` comes 2 cycles after release, and `step_count` is continuous.
- **Priority:** `game_over` and `start` pulsed in the same cycle during RUN → OVER. A later `start` → RUN with `step_count`=0, and all lanes fire on the first tick.
